uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Parameter DEPTH_LOG2, default 4, SHALL set the FIFO depth to 2^DEPTH_LOG2 entries.
REQ-003 Parameter AF_THRESH, default 12, SHALL set the almost-full level.
REQ-004 clk  input  1  system clock; all state changes on the rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 rx_data  input  8  received byte from the upstream UART receiver.
REQ-007 rx_valid  input  1  single-cycle strobe; rx_data and rx_error are valid when it is high.
REQ-008 rx_error  input  1  stop-bit (framing) error flag for the byte on rx_data.
REQ-009 m_data  output  8  head-of-FIFO byte.
REQ-010 m_error  output  1  framing-error tag of the head-of-FIFO byte.
REQ-011 m_valid  output  1  the FIFO is non-empty and m_data/m_error are valid.
REQ-012 m_ready  input  1  consumer accept.
REQ-013 level  output  DEPTH_LOG2+1  current occupancy, range 0..2^DEPTH_LOG2.
REQ-014 almost_full  output  1  high when level >= AF_THRESH.
REQ-015 overflow  output  1  sticky flag: a byte was lost because the FIFO was full.
REQ-016 err_cnt  output  8  saturating count of bytes received with rx_error=1.
REQ-017 stats_clr  input  1  single-cycle clear of overflow and err_cnt.

Function
REQ-018 A write SHALL occur on an edge where rx_valid=1 and the FIFO is not full, or where it is full and a read occurs on the same edge.
REQ-019 A read SHALL occur on an edge where m_valid=1 and m_ready=1.
REQ-020 The output SHALL be first-word-fall-through: after the write edge into an empty FIFO, m_valid=1 and m_data/m_error present that byte in the next cycle, with no extra latency.
REQ-021 m_data/m_error SHALL be driven from the storage entry at the read pointer and SHALL hold while m_valid=1 and m_ready=0.
REQ-022 Read and write pointers SHALL be DEPTH_LOG2 bits and wrap modulo 2^DEPTH_LOG2; level SHALL track occupancy exactly.
REQ-023 Simultaneous read and write SHALL leave level unchanged, including at full.
REQ-024 When rx_valid=1, the FIFO is full, and no read occurs on that edge, the byte SHALL be dropped and overflow SHALL be set on that edge.
REQ-025 On rx_valid=1 with rx_error=1, err_cnt SHALL increment by 1, saturate at 255, and count regardless of whether the byte is stored.
REQ-026 stats_clr=1 SHALL clear overflow and err_cnt; if a set/increment event occurs on the same edge, the event SHALL take priority (overflow=1, err_cnt=1).
REQ-027 stats_clr SHALL NOT affect FIFO contents or pointers.
REQ-028 m_ready asserted while m_valid=0 SHALL have no effect.

Reset
REQ-029 While rst=1 at a clock edge, pointers, level, overflow and err_cnt SHALL become 0, m_valid=0 and almost_full=0; storage contents need not be cleared.
REQ-030 Reset SHALL take priority over any simultaneous rx_valid, read or stats_clr; bytes in flight SHALL be discarded.

Configuration
REQ-031 With macro UART_RX_FIFO_ERR_DROP_EN defined, bytes with rx_error=1 SHALL NOT be written (still counted in err_cnt, never set overflow), and m_error SHALL be tied to 0.
REQ-032 With UART_RX_FIFO_ERR_DROP_EN undefined, errored bytes SHALL be stored with m_error=1 and are subject to the normal full/overflow rules.

Verification
REQ-033 Write 0x55 into an empty FIFO, m_ready=0 -> next cycle m_valid=1, m_data=0x55, level=1; hold 10 cycles, output unchanged.
REQ-034 Write 16 bytes 0x00..0x0F, then a 17th byte 0xAA with m_ready=0 -> level=16, overflow=1, almost_full=1; drain and read exactly 0x00..0x0F in order.
REQ-035 Full FIFO with rx_valid=1 and m_ready=1 on the same edge -> level stays 16, overflow stays 0, and the new byte is read last.
REQ-036 Send 300 bytes with rx_error=1 -> err_cnt=255; then stats_clr together with one more errored byte -> err_cnt=1.
REQ-037 Send byte 0x3C with rx_error=1 -> macro undefined: m_valid=1, m_data=0x3C, m_error=1; macro defined: m_valid stays 0, err_cnt=1.
REQ-038 Assert rst with 5 entries stored and a concurrent write -> next cycle level=0, m_valid=0, overflow=0, err_cnt=0.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo_if
// Brief    : Byte-stream bundle between a UART receiver, the RX FIFO and its
//            consumer (receive strobe side plus valid/ready head-of-FIFO side).
// Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_fifo_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_error;
    logic [7:0] m_data;
    logic       m_error;
    logic       m_valid;
    logic       m_ready;

    // Environment side: UART receiver feeding bytes and consumer accepting them
    modport master (
        output rx_data, rx_valid, rx_error, m_ready,
        input  m_data, m_error, m_valid
    );

    // FIFO side
    modport slave (
        input  rx_data, rx_valid, rx_error, m_ready,
        output m_data, m_error, m_valid
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : First-word-fall-through receive FIFO with framing-error tagging,
//            sticky overflow and saturating error counter.
//            Macro UART_RX_FIFO_ERR_DROP_EN discards errored bytes instead.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int AF_THRESH  = 12
) (
    input  wire logic            clk,
    input  wire logic            rst,
    uart_rx_fifo_if.slave        bus,
    input  wire logic            stats_clr,
    output logic [DEPTH_LOG2:0]  level,
    output logic                 almost_full,
    output logic                 overflow,
    output logic [7:0]           err_cnt
);

    localparam int                c_DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_FULL_LVL = (DEPTH_LOG2 + 1)'(c_DEPTH);
`ifdef UART_RX_FIFO_ERR_DROP_EN
    localparam int                c_W        = 8;
`else
    localparam int                c_W        = 9;
`endif

    logic [c_W-1:0]        r_mem [c_DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic                  r_overflow;
    logic [7:0]            r_err_cnt;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_rd;
    logic                  w_wr_req;
    logic                  w_wr;
    logic                  w_ovf_evt;
    logic                  w_err_evt;
    logic [c_W-1:0]        w_wr_word;
    logic [c_W-1:0]        w_head;

    always_comb begin
        w_full    = (r_level == c_FULL_LVL);
        w_empty   = (r_level == '0);
        w_rd      = !w_empty && bus.m_ready;
`ifdef UART_RX_FIFO_ERR_DROP_EN
        w_wr_req  = bus.rx_valid && !bus.rx_error;
        w_wr_word = bus.rx_data;
`else
        w_wr_req  = bus.rx_valid;
        w_wr_word = {bus.rx_error, bus.rx_data};
`endif
        // A full FIFO still accepts a byte when the head leaves on the same edge
        w_wr      = w_wr_req && (!w_full || w_rd);
        w_ovf_evt = w_wr_req && w_full && !w_rd;
        w_err_evt = bus.rx_valid && bus.rx_error;
        w_head    = r_mem[r_rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (!rst && w_wr) begin
            r_mem[r_wr_ptr] <= w_wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
            end
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + (DEPTH_LOG2 + 1)'(1);
                2'b01:   r_level <= r_level - (DEPTH_LOG2 + 1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Counting/setting events win over a same-edge clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
            r_err_cnt  <= 8'd0;
        end else begin
            if (w_ovf_evt) begin
                r_overflow <= 1'b1;
            end else if (stats_clr) begin
                r_overflow <= 1'b0;
            end

            if (w_err_evt) begin
                if (stats_clr) begin
                    r_err_cnt <= 8'd1;
                end else if (r_err_cnt != 8'hFF) begin
                    r_err_cnt <= r_err_cnt + 8'd1;
                end
            end else if (stats_clr) begin
                r_err_cnt <= 8'd0;
            end
        end
    end

    assign bus.m_valid = !w_empty;
    assign bus.m_data  = w_head[7:0];
`ifdef UART_RX_FIFO_ERR_DROP_EN
    assign bus.m_error = 1'b0;
`else
    assign bus.m_error = w_head[8];
`endif

    assign level       = r_level;
    assign almost_full = (int'(r_level) >= AF_THRESH);
    assign overflow    = r_overflow;
    assign err_cnt     = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo
// Brief    : Self-checking bench for uart_rx_fifo: queue-based reference model
//            compared every cycle, plus directed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    localparam int DL    = 4;
    localparam int AF    = 12;
    localparam int DEPTH = 1 << DL;
`ifdef UART_RX_FIFO_ERR_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          stats_clr;
    logic [DL:0]   level;
    logic          almost_full;
    logic          overflow;
    logic [7:0]    err_cnt;

    uart_rx_fifo_if bus ();

    uart_rx_fifo #(
        .DEPTH_LOG2 (DL),
        .AF_THRESH  (AF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .stats_clr   (stats_clr),
        .level       (level),
        .almost_full (almost_full),
        .overflow    (overflow),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     nm, act, act, exp, exp, $time);
        end
    endtask

    // Reference model: queue of {error, data}, updated on each rising edge
    logic [8:0] mq [$];
    int         m_err = 0;
    bit         m_ovf = 1'b0;
    bit         chk_en = 1'b0;

    always @(posedge clk) begin : model
        bit rd;
        bit wr_req;
        bit full_b;
        bit ovf_evt;
        if (rst) begin
            mq.delete();
            m_err = 0;
            m_ovf = 1'b0;
        end else begin
            full_b  = (mq.size() == DEPTH);
            rd      = (mq.size() != 0) && bus.m_ready;
            wr_req  = bus.rx_valid && !(DROP && bus.rx_error);
            ovf_evt = 1'b0;
            if (rd) void'(mq.pop_front());
            if (wr_req) begin
                if (!full_b || rd) mq.push_back({(DROP ? 1'b0 : bus.rx_error), bus.rx_data});
                else ovf_evt = 1'b1;
            end
            if (ovf_evt) m_ovf = 1'b1;
            else if (stats_clr) m_ovf = 1'b0;
            if (bus.rx_valid && bus.rx_error) m_err = stats_clr ? 1 : ((m_err >= 255) ? 255 : m_err + 1);
            else if (stats_clr) m_err = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_valid", int'(bus.m_valid), int'(mq.size() != 0));
            if (mq.size() != 0) begin
                chk("m_data", int'(bus.m_data), int'(mq[0][7:0]));
                chk("m_error", int'(bus.m_error), int'(mq[0][8]));
            end
            chk("level", int'(level), mq.size());
            chk("almost_full", int'(almost_full), int'(mq.size() >= AF));
            chk("overflow", int'(overflow), int'(m_ovf));
            chk("err_cnt", int'(err_cnt), m_err);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
        bus.rx_error = 1'b0;
        stats_clr    = 1'b0;
    endtask

    task automatic push(input logic [7:0] d, input logic e);
        bus.rx_data  = d;
        bus.rx_error = e;
        bus.rx_valid = 1'b1;
        tick();
    endtask

    task automatic drain();
        bus.m_ready = 1'b1;
        repeat (DEPTH + 1) tick();
        bus.m_ready = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        stats_clr    = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_error = 1'b0;
        bus.rx_data  = 8'h00;
        bus.m_ready  = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_level", int'(level), 0);
        chk("rst_m_valid", int'(bus.m_valid), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_err_cnt", int'(err_cnt), 0);

        // Single byte falls through and holds while not accepted
        push(8'h55, 1'b0);
        chk("fwft_valid", int'(bus.m_valid), 1);
        chk("fwft_data", int'(bus.m_data), 'h55);
        chk("fwft_level", int'(level), 1);
        repeat (10) tick();
        chk("hold_data", int'(bus.m_data), 'h55);
        chk("hold_level", int'(level), 1);
        drain();
        chk("drain1_level", int'(level), 0);

        // Fill (pointers wrap), overflow on the 17th byte, ordered drain
        for (int i = 0; i < DEPTH; i++) begin
            push(8'(i), 1'b0);
            if (i == AF - 2) chk("af_below", int'(almost_full), 0);
            if (i == AF - 1) chk("af_at", int'(almost_full), 1);
        end
        push(8'hAA, 1'b0);
        chk("full_level", int'(level), 16);
        chk("full_overflow", int'(overflow), 1);
        chk("full_af", int'(almost_full), 1);
        bus.m_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("ordered_data", int'(bus.m_data), i);
            tick();
        end
        bus.m_ready = 1'b0;
        chk("empty_after_drain", int'(bus.m_valid), 0);
        stats_clr = 1'b1;
        tick();
        chk("ovf_cleared", int'(overflow), 0);

        // Full FIFO with simultaneous read and write
        for (int i = 0; i < DEPTH; i++) push(8'(8'h10 + i), 1'b0);
        bus.rx_data  = 8'h77;
        bus.rx_valid = 1'b1;
        bus.m_ready  = 1'b1;
        tick();
        bus.m_ready = 1'b0;
        chk("rw_full_level", int'(level), 16);
        chk("rw_full_ovf", int'(overflow), 0);
        bus.m_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            chk("rw_order", int'(bus.m_data), (i < DEPTH - 1) ? ('h11 + i) : 'h77);
            tick();
        end
        bus.m_ready = 1'b0;

        // Error counter saturation, then clear with a same-edge error
        bus.m_ready = 1'b1;
        for (int i = 0; i < 300; i++) push(8'(i), 1'b1);
        chk("err_sat", int'(err_cnt), 255);
        stats_clr = 1'b1;
        push(8'hE0, 1'b1);
        chk("err_clr_evt", int'(err_cnt), 1);
        tick();
        bus.m_ready = 1'b0;
        chk("err_drain_level", int'(level), 0);

        // Errored byte handling
        stats_clr = 1'b1;
        tick();
        push(8'h3C, 1'b1);
        chk("err_byte_cnt", int'(err_cnt), 1);
        if (DROP) begin
            chk("drop_valid", int'(bus.m_valid), 0);
        end else begin
            chk("keep_valid", int'(bus.m_valid), 1);
            chk("keep_data", int'(bus.m_data), 'h3C);
            chk("keep_error", int'(bus.m_error), 1);
        end
        drain();

        // Reset with stored entries and a concurrent write
        for (int i = 0; i < 5; i++) push(8'(8'h60 + i), 1'b0);
        bus.rx_data  = 8'h99;
        bus.rx_valid = 1'b1;
        bus.rx_error = 1'b1;
        bus.m_ready  = 1'b1;
        rst          = 1'b1;
        tick();
        rst         = 1'b0;
        bus.m_ready = 1'b0;
        chk("rst2_level", int'(level), 0);
        chk("rst2_valid", int'(bus.m_valid), 0);
        chk("rst2_overflow", int'(overflow), 0);
        chk("rst2_err_cnt", int'(err_cnt), 0);
        push(8'h42, 1'b0);
        chk("post_rst_data", int'(bus.m_data), 'h42);
        chk("post_rst_level", int'(level), 1);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
